// File: rtl/ghp_pkg.sv
// ghp_pkg: shared types, sizes and counter helpers for the global-history PHT controller
package ghp_pkg;
  localparam int HIST_W = 12;
  localparam int CTR_W  = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CTR_W-1:0] WEAK_TAKEN = {1'b1, {(CTR_W-1){1'b0}}};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD} state_t;

  // hist is the pre-shift history that indexed the PHT, ctr the value read, pred the direction given
  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic [CTR_W-1:0]  ctr;
    logic              pred;
  } ghp_entry_t;

  function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr, input logic taken);
    return taken ? ((&ctr) ? ctr : ctr + 1'b1) : ((|ctr) ? ctr - 1'b1 : ctr);
  endfunction

  // Taken iff the counter is in the upper half, i.e. its MSB is set
  function automatic logic ctr_taken(input logic [CTR_W-1:0] ctr);
    return ctr[CTR_W-1];
  endfunction
endpackage

// File: rtl/ghp_inflight_fifo.sv
// ghp_inflight_fifo: in-order queue of unresolved predictions; clear beats push and pop
module ghp_inflight_fifo
  import ghp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  ghp_entry_t       push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output ghp_entry_t       head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  ghp_entry_t       mem_q [DEPTH];
  ghp_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // Next pointers/count; a flush drops everything, including a same-cycle push
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) mem_d[wr_q] = push_data;
      wr_d  = push ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d  = pop ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage and pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ghp_controller.sv
// ghp_controller: GHR owner, PHT init sweep and single-port PHT arbiter with mispredict recovery
module ghp_controller
  import ghp_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lookup_v,
  output logic              lookup_ready,
  output logic              pred_v,
  output logic              pred_taken,
  input  logic              resolve_v,
  input  logic              resolve_taken,
  output logic              flush,
  output logic              err,
  output logic              init_done,
  output logic [HIST_W-1:0] ghr_spec,
  output logic              pht_req_v,
  output logic              pht_we,
  output logic [HIST_W-1:0] pht_idx,
  output logic [CTR_W-1:0]  pht_wdata,
  input  logic [CTR_W-1:0]  pht_rdata
);
  state_t            state_q, state_d;
  logic [HIST_W-1:0] init_idx_q, init_idx_d, ghr_q, ghr_d;
  logic              init_done_q, init_done_d, flush_q, flush_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt;
  ghp_entry_t        head, push_data;
  logic              res_act, do_res, mis, push;

  assign init_done = init_done_q;
  assign ghr_spec  = ghr_q;
  assign flush     = flush_q;
  assign err       = err_q;

  ghp_inflight_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (do_res),
    .clear     (mis),
    .count     (cnt),
    .head      (head)
  );

  // Resolution, prediction, GHR recovery and PHT port arbitration (resolve write beats lookup read)
  always_comb begin
    res_act      = resolve_v & (state_q != S_INIT);
    do_res       = res_act & (cnt != '0);
    mis          = do_res & (resolve_taken != head.pred);
    lookup_ready = (state_q == S_IDLE) & (cnt < DEPTH_C) & ~resolve_v & init_done_q;
    pred_v       = (state_q == S_RD) & ~mis;
    pred_taken   = pred_v & ctr_taken(pht_rdata);
    push         = pred_v;
    push_data    = '{hist: ghr_q, ctr: pht_rdata, pred: pred_taken};
    ghr_d        = mis ? {head.hist[HIST_W-2:0], resolve_taken}
                 : pred_v ? {ghr_q[HIST_W-2:0], pred_taken} : ghr_q;
    flush_d      = mis;
    err_d        = err_q | (res_act & (cnt == '0));
    pht_req_v    = 1'b0;
    pht_we       = 1'b0;
    pht_idx      = '0;
    pht_wdata    = '0;
    if (state_q == S_INIT) begin
      pht_req_v = reset_n;
      pht_we    = reset_n;
      pht_idx   = init_idx_q;
      pht_wdata = WEAK_TAKEN;
    end else if (do_res) begin
      pht_req_v = 1'b1;
      pht_we    = 1'b1;
      pht_idx   = head.hist;
      pht_wdata = sat_update(head.ctr, resolve_taken);
    end else if (lookup_v & lookup_ready) begin
      pht_req_v = 1'b1;
      pht_idx   = ghr_q;
    end
  end

  // Sequencing: sweep every PHT entry once, then alternate issue/read for accepted lookups
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE:  state_d = (lookup_v & lookup_ready) ? S_RD : S_IDLE;
      S_RD:    state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Controller state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      ghr_q       <= ghr_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_ghp_controller.sv
// tb_ghp_controller: random and directed stimulus against a queue-based predictor model
module tb_ghp_controller;
  logic        clock, reset_n, lookup_v, resolve_v, resolve_taken;
  logic        lookup_ready, pred_v, pred_taken, flush, err, init_done;
  logic [11:0] ghr_spec, pht_idx;
  logic        pht_req_v, pht_we;
  logic [1:0]  pht_wdata, pht_rdata;
  logic        poke_v;
  logic [11:0] poke_idx;
  logic [1:0]  poke_data;
  logic [1:0]  mem [4096];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {int hist; int ctr; bit pred;} ent_t;
  ent_t q[$];
  int   sh[4096];
  int   m_init, m_rdctr, m_ghr;
  bit   m_pend, m_err, m_flush;

  ghp_controller dut (
    .clock(clock), .reset_n(reset_n), .lookup_v(lookup_v), .lookup_ready(lookup_ready),
    .pred_v(pred_v), .pred_taken(pred_taken), .resolve_v(resolve_v), .resolve_taken(resolve_taken),
    .flush(flush), .err(err), .init_done(init_done), .ghr_spec(ghr_spec),
    .pht_req_v(pht_req_v), .pht_we(pht_we), .pht_idx(pht_idx), .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial pht_rdata = 2'd0;
  // Single-port PHT: registered read, no bypass; bench pokes share the write side
  always @(posedge clock) begin
    if (pht_req_v) begin
      if (pht_we) mem[pht_idx] <= pht_wdata;
      else pht_rdata <= mem[pht_idx];
    end
    if (poke_v) mem[poke_idx] <= poke_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int satm(input int c, input bit t);
    return t ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
  endfunction

  // Reference model: checks this cycle's outputs, then advances to the post-edge state
  always @(negedge clock) begin : model
    bit   idone, res, wr, mis, rd, erdy, epv, ept;
    ent_t e;
    if (!reset_n) begin
      chk("rst_pred_v", pred_v, 0);
      chk("rst_flush", flush, 0);
      chk("rst_err", err, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_lookup_ready", lookup_ready, 0);
      chk("rst_pht_req_v", pht_req_v, 0);
      chk("rst_ghr", ghr_spec, 0);
      m_init = 0; m_pend = 0; m_ghr = 0; m_err = 0; m_flush = 0; m_rdctr = 0;
      q.delete();
    end else begin
      idone = (m_init == 4096);
      res   = idone && resolve_v;
      wr    = res && (q.size() > 0);
      e     = '{0, 0, 0};
      if (wr) e = q[0];
      mis   = wr && (resolve_taken != e.pred);
      erdy  = idone && !m_pend && (q.size() < 4) && !resolve_v;
      epv   = m_pend && !mis;
      ept   = epv && (m_rdctr >= 2);
      rd    = erdy && lookup_v;
      chk("init_done", init_done, idone);
      chk("ghr_spec", ghr_spec, m_ghr);
      chk("err", err, m_err);
      chk("flush", flush, m_flush);
      chk("lookup_ready", lookup_ready, erdy);
      chk("pred_v", pred_v, epv);
      if (epv) chk("pred_taken", pred_taken, ept);
      chk("pht_req_v", pht_req_v, !idone || wr || rd);
      if (!idone) begin
        chk("init_we", pht_we, 1);
        chk("init_idx", pht_idx, m_init);
        chk("init_wdata", pht_wdata, 2);
      end else if (wr) begin
        chk("upd_we", pht_we, 1);
        chk("upd_idx", pht_idx, e.hist);
        chk("upd_wdata", pht_wdata, satm(e.ctr, resolve_taken));
      end else if (rd) begin
        chk("rd_we", pht_we, 0);
        chk("rd_idx", pht_idx, m_ghr);
      end
      if (!idone) begin sh[m_init] = 2; m_init++; end
      if (rd) m_rdctr = sh[m_ghr];
      if (res && q.size() == 0) m_err = 1;
      if (wr) begin
        sh[e.hist] = satm(e.ctr, resolve_taken);
        if (mis) begin
          q.delete();
          m_ghr = (e.hist * 2 + int'(resolve_taken)) % 4096;
        end else void'(q.pop_front());
      end
      if (epv) begin
        q.push_back('{m_ghr, m_rdctr, ept});
        m_ghr = (m_ghr * 2 + int'(ept)) % 4096;
      end
      m_flush = mis;
      m_pend  = rd;
    end
    if (poke_v) sh[poke_idx] = int'(poke_data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Must be called right after reset_n is released, before the next negedge
  task automatic wait_init();
    int c = 0;
    @(negedge clock);
    chk("sweep_start_idx", pht_idx, 0);
    while (!init_done && c < 5000) begin
      c++;
      @(negedge clock);
    end
    chk("init_cycles", c, 4096);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; lookup_v = 0; resolve_v = 0; resolve_taken = 0;
    poke_v = 0; poke_idx = 0; poke_data = 0;
    repeat (3) tick();
    reset_n = 1;
    wait_init();
    tick(); poke_v = 1; poke_idx = 12'd0; poke_data = 2'd3;
    tick(); poke_v = 0; lookup_v = 1;
    tick(); lookup_v = 0;
    @(negedge clock);
    chk("lit_pred_v", pred_v, 1);
    chk("lit_pred_taken", pred_taken, 1);
    tick();
    @(negedge clock);
    chk("lit_ghr_1", ghr_spec, 12'h001);
    tick(); resolve_v = 1; resolve_taken = 1;
    @(negedge clock);
    chk("lit_res_we", pht_we, 1);
    chk("lit_res_idx", pht_idx, 0);
    chk("lit_res_wdata", pht_wdata, 3);
    tick(); resolve_v = 0;
    @(negedge clock);
    chk("lit_no_flush", flush, 0);
    tick(); lookup_v = 1;
    tick(); lookup_v = 0;
    @(negedge clock);
    chk("lit_pred2_taken", pred_taken, 1);
    tick(); resolve_v = 1; resolve_taken = 0;
    @(negedge clock);
    chk("lit_mis_idx", pht_idx, 1);
    chk("lit_mis_wdata", pht_wdata, 1);
    tick(); resolve_v = 0;
    @(negedge clock);
    chk("lit_flush", flush, 1);
    chk("lit_ghr_2", ghr_spec, 12'h002);
    tick();
    @(negedge clock);
    chk("lit_flush_pulse", flush, 0);
    tick(); lookup_v = 1;
    repeat (10) tick();
    @(negedge clock);
    chk("lit_full_ready", lookup_ready, 0);
    tick(); resolve_v = 1; resolve_taken = 1'($urandom % 2);
    @(negedge clock);
    chk("lit_prio_we", pht_we, 1);
    chk("lit_prio_ready", lookup_ready, 0);
    tick(); resolve_v = 0; lookup_v = 0;
    repeat (2) tick();
    for (int i = 0; i < 4096; i++) begin
      poke_v = 1; poke_idx = 12'(i); poke_data = 2'($urandom % 4);
      tick();
    end
    poke_v = 0;
    repeat (3000) begin
      lookup_v      = 1'($urandom % 2);
      resolve_v     = (q.size() > 0) && ($urandom % 3 == 0);
      resolve_taken = 1'($urandom % 2);
      tick();
    end
    lookup_v = 0; resolve_v = 0;
    repeat (2) tick();
    begin
      int g = 0;
      while (q.size() > 0 && g < 20) begin
        resolve_v = 1; resolve_taken = 1'($urandom % 2);
        tick();
        g++;
      end
      resolve_v = 0;
      chk("drain_bound", g < 20, 1);
    end
    tick();
    @(negedge clock);
    chk("lit_err_clear", err, 0);
    tick(); resolve_v = 1;
    tick(); resolve_v = 0;
    @(negedge clock);
    chk("lit_err_set", err, 1);
    repeat (5) tick();
    @(negedge clock);
    chk("lit_err_sticky", err, 1);
    tick(); reset_n = 0;
    tick(); reset_n = 1;
    repeat (100) tick();
    reset_n = 0;
    @(negedge clock);
    chk("lit_midsweep_err", err, 0);
    chk("lit_midsweep_done", init_done, 0);
    tick(); reset_n = 1;
    wait_init();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
